// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, line levels and parity helper
// used by both the transmitter and the receiver.
package uart_pkg;

    localparam int unsigned DATA_BITS   = 8;
    localparam logic        START_LEVEL = 1'b0;
    localparam logic        STOP_LEVEL  = 1'b1;
    localparam logic        IDLE_LEVEL  = 1'b1;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_BIT  = 3'd1,
        PAYLOAD    = 3'd2,
        PARITY_BIT = 3'd3,
        STOP_BIT   = 3'd4,
        DONE       = 3'd5
    } uart_state_e;

    // Even parity bit: makes the total count of ones across data + parity even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..N-1 while enabled and flags the last cycle of a bit.
// A period of 0 behaves as 1 so the line can never stall.
module uart_bit_timer (
    input  logic        clk,
    input  logic        rstN,
    input  logic        en_i,
    input  logic        clear_i,
    input  logic [31:0] period_i,
    output logic        bit_end_o
);

    logic [31:0] count_q;
    logic [31:0] count_d;
    logic [31:0] period_eff_s;

    assign period_eff_s = (period_i == 32'd0) ? 32'd1 : period_i;
    assign bit_end_o    = en_i && (count_q == (period_eff_s - 32'd1));

    // Next count: restart on clear, wrap at bit end, hold at zero when idle.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = 32'd0;
        end else if (!en_i) begin
            count_d = 32'd0;
        end else if (bit_end_o) begin
            count_d = 32'd0;
        end else begin
            count_d = count_q + 32'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 frames, LSB first, runtime bit period latched per byte.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx #(
    parameter int unsigned DATA_BITS = uart_pkg::DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic [31:0]          clocksPerBit,
    input  logic                 txStart,
    input  logic [DATA_BITS-1:0] txByte,
    output logic                 txData,
    output logic                 txBusy,
    output logic                 txDone
);

    import uart_pkg::*;

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [31:0]          period_q, period_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic                 tx_data_q, tx_data_d;
    logic                 tx_busy_q, tx_busy_d;
    logic                 tx_done_q, tx_done_d;
    logic                 timer_clr_s;
    logic                 timer_en_s;
    logic                 bit_end_s;

    assign timer_en_s = (state_q != IDLE) && (state_q != DONE);

    uart_bit_timer u_bit_timer (
        .clk       (clk),
        .rstN      (rstN),
        .en_i      (timer_en_s),
        .clear_i   (timer_clr_s),
        .period_i  (period_q),
        .bit_end_o (bit_end_s)
    );

    // Frame sequencing; every output is computed one cycle ahead and registered.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        period_d    = period_q;
        bit_cnt_d   = bit_cnt_q;
        tx_data_d   = tx_data_q;
        tx_busy_d   = tx_busy_q;
        tx_done_d   = 1'b0;
        timer_clr_s = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                // DONE accepts exactly like IDLE, giving back-to-back frames.
                if (txStart) begin
                    shift_d     = txByte;
                    period_d    = clocksPerBit;
                    tx_data_d   = START_LEVEL;
                    tx_busy_d   = 1'b1;
                    timer_clr_s = 1'b1;
                    state_d     = START_BIT;
                end else begin
                    tx_data_d = IDLE_LEVEL;
                    tx_busy_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            START_BIT: begin
                if (bit_end_s) begin
                    bit_cnt_d = 3'd0;
                    tx_data_d = shift_q[0];
                    state_d   = PAYLOAD;
                end else begin
                    state_d = START_BIT;
                end
            end
            PAYLOAD: begin
                if (bit_end_s) begin
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                        tx_data_d = even_parity(shift_q);
                        state_d   = PARITY_BIT;
`else
                        tx_data_d = STOP_LEVEL;
                        state_d   = STOP_BIT;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_data_d = shift_q[bit_cnt_q + 3'd1];
                    end
                end else begin
                    state_d = PAYLOAD;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY_BIT: begin
                if (bit_end_s) begin
                    tx_data_d = STOP_LEVEL;
                    state_d   = STOP_BIT;
                end else begin
                    state_d = PARITY_BIT;
                end
            end
`endif
            STOP_BIT: begin
                if (bit_end_s) begin
                    tx_data_d = IDLE_LEVEL;
                    tx_busy_d = 1'b0;
                    tx_done_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    state_d = STOP_BIT;
                end
            end
            default: begin
                tx_data_d = IDLE_LEVEL;
                tx_busy_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // State and output registers; reset forces an idle-high line at once.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            period_q  <= 32'd0;
            bit_cnt_q <= 3'd0;
            tx_data_q <= IDLE_LEVEL;
            tx_busy_q <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            period_q  <= period_d;
            bit_cnt_q <= bit_cnt_d;
            tx_data_q <= tx_data_d;
            tx_busy_q <= tx_busy_d;
            tx_done_q <= tx_done_d;
        end
    end

    assign txData = tx_data_q;
    assign txBusy = tx_busy_q;
    assign txDone = tx_done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues the expected per-cycle line/busy/done
// trace of each frame; a negedge monitor pops and compares it against the DUT.
module tb_uart_tx;

    logic        clk;
    logic        rstN;
    logic [31:0] clocksPerBit;
    logic        txStart;
    logic [7:0]  txByte;
    logic        txData;
    logic        txBusy;
    logic        txDone;

    int n_vec;
    int n_err;

    typedef struct packed {
        logic [7:0] id;
        logic       d;
        logic       b;
        logic       dn;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Frames in transmission order, first bit in the MSB of FB bits.
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
    localparam logic [10:0] F_A5 = 11'b01010010101;
    localparam logic [10:0] F_00 = 11'b00000000001;
    localparam logic [10:0] F_FF = 11'b01111111101;
    localparam logic [10:0] F_3C = 11'b00011110001;
    localparam logic [10:0] F_F0 = 11'b00000111101;
    localparam logic [10:0] F_81 = 11'b01000000101;
    localparam logic [10:0] F_07 = 11'b01110000011;
`else
    localparam int FB = 10;
    localparam logic [10:0] F_A5 = 11'b00101001011;
    localparam logic [10:0] F_00 = 11'b00000000001;
    localparam logic [10:0] F_FF = 11'b00111111111;
    localparam logic [10:0] F_3C = 11'b00001111001;
    localparam logic [10:0] F_F0 = 11'b00000011111;
    localparam logic [10:0] F_81 = 11'b00100000011;
    localparam logic [10:0] F_07 = 11'b00111000001;
`endif

    uart_tx dut (
        .clk          (clk),
        .rstN         (rstN),
        .clocksPerBit (clocksPerBit),
        .txStart      (txStart),
        .txByte       (txByte),
        .txData       (txData),
        .txBusy       (txBusy),
        .txDone       (txDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: data/busy/done got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk($sformatf("trace_id%0d", mon_e.id), {txData, txBusy, txDone},
                {mon_e.d, mon_e.b, mon_e.dn});
        end
    end

    task automatic push(input int id, input logic d, input logic b, input logic dn);
        exp_t e;
        e.id = id[7:0];
        e.d  = d;
        e.b  = b;
        e.dn = dn;
        exp_q.push_back(e);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input int id);
        for (int i = 0; i < n; i++) begin
            push(id, 1'b1, 1'b0, 1'b0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_req(input logic [7:0] b, input logic [31:0] cpb);
        txByte       = b;
        clocksPerBit = cpb;
        txStart      = 1'b1;
        @(posedge clk);
        #1;
        txStart = 1'b0;
        txByte  = ~b;
    endtask

    task automatic push_frame(input int id, input logic [10:0] bits, input int hold);
        for (int k = 0; k < FB; k++) begin
            for (int j = 0; j < hold; j++) begin
                push(id, bits[FB-1-k], 1'b1, 1'b0);
            end
        end
        push(id, 1'b1, 1'b0, 1'b1);
    endtask

    // Leaves the caller standing in the DONE cycle of the frame.
    task automatic run_frame(input int id, input logic [7:0] b, input logic [31:0] cpb,
                             input int hold, input logic [10:0] bits, input bit from_done);
        if (!from_done) push(id, 1'b1, 1'b0, 1'b0);
        start_req(b, cpb);
        push_frame(id, bits, hold);
        wait_cycles(FB * hold);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

    initial begin
        n_vec        = 0;
        n_err        = 0;
        rstN         = 1'b0;
        txStart      = 1'b0;
        txByte       = 8'h00;
        clocksPerBit = 32'd4;
        @(posedge clk);
        #1;
        idle(3, 1);
        rstN = 1'b1;
        idle(20, 2);

        run_frame(3, 8'hA5, 32'd4, 4, F_A5, 1'b0);
        wait_cycles(1);
        idle(3, 4);

        run_frame(5, 8'h00, 32'd3, 3, F_00, 1'b0);
        run_frame(6, 8'hFF, 32'd3, 3, F_FF, 1'b1);
        wait_cycles(1);
        idle(3, 7);

        // Start request and period change mid-frame must both be ignored.
        push(8, 1'b1, 1'b0, 1'b0);
        start_req(8'h3C, 32'd4);
        push_frame(8, F_3C, 4);
        wait_cycles(5);
        txStart      = 1'b1;
        txByte       = 8'h55;
        clocksPerBit = 32'd8;
        wait_cycles(1);
        txStart = 1'b0;
        wait_cycles(FB * 4 - 6);
        wait_cycles(1);
        clocksPerBit = 32'd4;
        idle(3, 9);

        // Asynchronous reset in the middle of data bit 3.
        push(10, 1'b1, 1'b0, 1'b0);
        start_req(8'hF0, 32'd5);
        push_frame(10, F_F0, 5);
        wait_cycles(21);
        exp_q.delete();
        rstN = 1'b0;
        #1;
        chk("async_reset", {txData, txBusy, txDone}, 3'b100);
        idle(2, 11);
        rstN = 1'b1;
        idle(2, 12);
        run_frame(13, 8'h81, 32'd5, 5, F_81, 1'b0);
        wait_cycles(1);
        idle(3, 14);

        run_frame(15, 8'h07, 32'd2, 2, F_07, 1'b0);
        wait_cycles(1);
        idle(3, 16);

        // A zero bit period behaves as one cycle per bit.
        run_frame(17, 8'hA5, 32'd0, 1, F_A5, 1'b0);
        wait_cycles(1);
        idle(3, 18);

        wait_cycles(2);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL queue_drained: %0d entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
